io_port_ctrl: RTL and testbench

- Peripheral-side counterpart of the processor's I/O port interface.
- Receives words from an external source into an input FIFO and presents the FIFO head on the processor input port; the IN instruction's read strobe pops it.
- Captures OUT-instruction writes into an output FIFO that an external sink drains with a valid/ready handshake.
- Raises the processor interrupt request and tracks the request/acknowledge/RTI handshake with a small FSM.

---
 rtl/io_port_ctrl.sv | 116 +++++++++++
 tb/tb_io_port_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: processor I/O port peripheral with input/output FIFOs and an interrupt handshake FSM
// Optional build macro IO_IRQ_THRESHOLD_EN: request an interrupt once input occupancy reaches IRQ_THRESH
// instead of as soon as the input FIFO is non-empty.
module io_port_ctrl #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 4,
  parameter int IRQ_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ext_in_valid,
  input  logic [DATA_W-1:0]          ext_in_data,
  output logic                       ext_in_ready,
  output logic [DATA_W-1:0]          in_port,
  input  logic                       cpu_in_rd,
  input  logic                       cpu_out_wr,
  input  logic [DATA_W-1:0]          cpu_out_data,
  output logic                       ext_out_valid,
  output logic [DATA_W-1:0]          ext_out_data,
  input  logic                       ext_out_ready,
  output logic                       irq,
  input  logic                       int_ack,
  input  logic                       rti_done,
  output logic [$clog2(DEPTH):0]     in_count,
  output logic                       out_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("io_port_ctrl: DEPTH must be a power of 2 and at least 2");
  end
  if (IRQ_THRESH < 1 || IRQ_THRESH > DEPTH) begin : g_bad_thresh
    $error("io_port_ctrl: IRQ_THRESH must lie in 1..DEPTH");
  end
  logic [DATA_W-1:0] in_mem_q  [DEPTH];
  logic [DATA_W-1:0] out_mem_q [DEPTH];
  logic [PW-1:0]     in_wr_q, in_rd_q, out_wr_q, out_rd_q;
  logic [CW-1:0]     in_count_q, in_count_d, out_count_q, out_count_d;
  logic              in_push, in_pop, out_push, out_pop, out_full, out_drop;
  logic              overflow_q, irq_q, cond;
  state_t            state_q;
  // Input side: a pop on an empty FIFO is masked, so a same-cycle push/pop when empty is push-only.
  assign ext_in_ready = in_count_q != CW'(DEPTH);
  assign in_push      = ext_in_valid & ext_in_ready;
  assign in_pop       = cpu_in_rd & (in_count_q != '0);
  assign in_count_d   = in_count_q + CW'(in_push) - CW'(in_pop);
  assign in_port      = in_count_q != '0 ? in_mem_q[in_rd_q] : '0;
  assign in_count     = in_count_q;
  // Output side: a write into a full FIFO is still accepted when the sink drains the head that cycle.
  assign out_full      = out_count_q == CW'(DEPTH);
  assign ext_out_valid = out_count_q != '0;
  assign out_pop       = ext_out_valid & ext_out_ready;
  assign out_push      = cpu_out_wr & (~out_full | out_pop);
  assign out_drop      = cpu_out_wr & out_full & ~out_pop;
  assign out_count_d   = out_count_q + CW'(out_push) - CW'(out_pop);
  assign ext_out_data  = ext_out_valid ? out_mem_q[out_rd_q] : '0;
  assign out_overflow  = overflow_q;
  assign irq           = irq_q;
`ifdef IO_IRQ_THRESHOLD_EN
  assign cond = in_count_q >= CW'(IRQ_THRESH);
`else
  assign cond = in_count_q != '0;
`endif
  // FIFO storage needs no reset: reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (in_push) in_mem_q[in_wr_q] <= ext_in_data;
    if (out_push) out_mem_q[out_wr_q] <= cpu_out_data;
  end
  // Pointers and occupancy of both FIFOs; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_wr_q     <= '0;
      in_rd_q     <= '0;
      in_count_q  <= '0;
      out_wr_q    <= '0;
      out_rd_q    <= '0;
      out_count_q <= '0;
    end else begin
      in_wr_q     <= in_wr_q + PW'(in_push);
      in_rd_q     <= in_rd_q + PW'(in_pop);
      in_count_q  <= in_count_d;
      out_wr_q    <= out_wr_q + PW'(out_push);
      out_rd_q    <= out_rd_q + PW'(out_pop);
      out_count_q <= out_count_d;
    end
  end
  // Sticky record of any dropped OUT write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else if (out_drop) overflow_q <= 1'b1;
  end
  // Interrupt handshake: request, wait for acknowledge, then wait for RTI before re-arming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (cond) begin
                   state_q <= REQ;
                   irq_q   <= 1'b1;
                 end
        REQ:     if (int_ack) begin
                   state_q <= SERVICE;
                   irq_q   <= 1'b0;
                 end
        SERVICE: if (rti_done) state_q <= IDLE;
        default: begin
                   state_q <= IDLE;
                   irq_q   <= 1'b0;
                 end
      endcase
    end
  end
endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: vector table plus queue scoreboards for io_port_ctrl
module tb_io_port_ctrl;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ext_in_valid = 1'b0, cpu_in_rd = 1'b0, cpu_out_wr = 1'b0, ext_out_ready = 1'b0;
  logic int_ack = 1'b0, rti_done = 1'b0;
  logic [DW-1:0] ext_in_data = '0, cpu_out_data = '0;
  logic ext_in_ready, ext_out_valid, irq, out_overflow;
  logic [DW-1:0] in_port, ext_out_data;
  logic [CW-1:0] in_count;
  int total = 0;
  int bad = 0;
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_q[$];
  typedef struct {
    logic v; logic [15:0] d; logic rd, ack, rti;
    logic [2:0] cnt; logic rdy; logic [15:0] port; logic irq;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  io_port_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .IRQ_THRESH(2)) dut (
    .clk(clk), .rst(rst),
    .ext_in_valid(ext_in_valid), .ext_in_data(ext_in_data), .ext_in_ready(ext_in_ready),
    .in_port(in_port), .cpu_in_rd(cpu_in_rd),
    .cpu_out_wr(cpu_out_wr), .cpu_out_data(cpu_out_data),
    .ext_out_valid(ext_out_valid), .ext_out_data(ext_out_data), .ext_out_ready(ext_out_ready),
    .irq(irq), .int_ack(int_ack), .rti_done(rti_done),
    .in_count(in_count), .out_overflow(out_overflow)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_cnt"}, 32'(in_count), 0);
    chk({nm, "_rdy"}, 32'(ext_in_ready), 1);
    chk({nm, "_port"}, 32'(in_port), 0);
    chk({nm, "_ovalid"}, 32'(ext_out_valid), 0);
    chk({nm, "_odata"}, 32'(ext_out_data), 0);
    chk({nm, "_irq"}, 32'(irq), 0);
    chk({nm, "_ovf"}, 32'(out_overflow), 0);
  endtask
  task automatic drain(input string nm);
    ext_out_ready = 1'b1;
    for (int n = 0; n < 20 && out_q.size() > 0; n++) begin
      if (ext_out_valid) chk(nm, 32'(ext_out_data), 32'(out_q.pop_front()));
      step;
    end
    chk({nm, "_left"}, 32'(out_q.size()), 0);
    chk({nm, "_valid"}, 32'(ext_out_valid), 0);
    ext_out_ready = 1'b0;
  endtask
  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic rd, input logic ack,
                              input logic rti, input logic [2:0] cnt, input logic rdy,
                              input logic [15:0] port, input logic irq_e);
    vec_t r;
    r.v = v; r.d = d; r.rd = rd; r.ack = ack; r.rti = rti;
    r.cnt = cnt; r.rdy = rdy; r.port = port; r.irq = irq_e;
    return r;
  endfunction
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    step;
    step;
    chk_reset("rst_hold");
    rst = 1'b0;
    step;
    chk_reset("rst_idle");
    // fill / drain and interrupt handshake: v d rd ack rti | cnt rdy port irq
    tbl.push_back(mk(1, 16'h1111, 0, 0, 0, 1, 1, 16'h1111, 0));
    tbl.push_back(mk(1, 16'h2222, 0, 0, 0, 2, 1, 16'h1111, 1));
    tbl.push_back(mk(1, 16'h3333, 0, 0, 0, 3, 1, 16'h1111, 1));
    tbl.push_back(mk(1, 16'h4444, 0, 0, 0, 4, 0, 16'h1111, 1));
    tbl.push_back(mk(1, 16'h5555, 0, 0, 0, 4, 0, 16'h1111, 1));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 3, 1, 16'h2222, 1));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 2, 1, 16'h3333, 1));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 1, 1, 16'h4444, 1));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 1, 16'h0000, 1));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 1, 16'h0000, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 1, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 1, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 0));
    tbl.push_back(mk(1, 16'hBEEF, 0, 0, 0, 1, 1, 16'hBEEF, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 1, 16'hBEEF, 1));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 1, 16'h0000, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 1, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 1, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 0));
    tbl.push_back(mk(1, 16'h0C01, 0, 0, 0, 1, 1, 16'h0C01, 0));
    tbl.push_back(mk(1, 16'h0C02, 0, 0, 0, 2, 1, 16'h0C01, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 2, 1, 16'h0C01, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 1, 1, 16'h0C02, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 1, 16'h0C02, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 1, 16'h0C02, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 1, 1, 1, 16'h0C02, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 1, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 1, 16'h0000, 0));
    foreach (tbl[i]) begin
      ext_in_valid = tbl[i].v;
      ext_in_data = tbl[i].d;
      cpu_in_rd = tbl[i].rd;
      int_ack = tbl[i].ack;
      rti_done = tbl[i].rti;
      step;
      chk($sformatf("vec%0d_cnt", i), 32'(in_count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_rdy", i), 32'(ext_in_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_port", i), 32'(in_port), 32'(tbl[i].port));
`ifndef IO_IRQ_THRESHOLD_EN
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(tbl[i].irq));
`endif
    end
    {ext_in_valid, cpu_in_rd, int_ack, rti_done} = '0;
    ext_in_data = '0;
    // wrap: overlapped push/pop keeps occupancy at 1 while pointers lap the FIFO
    ext_in_valid = 1'b1;
    ext_in_data = 16'h00A0;
    in_q.push_back(16'h00A0);
    step;
    chk("wrap_cnt0", 32'(in_count), 1);
    for (int i = 1; i < 10; i++) begin
      chk($sformatf("wrap_head%0d", i - 1), 32'(in_port), 32'(in_q.pop_front()));
      ext_in_data = 16'h00A0 + 16'(i);
      in_q.push_back(ext_in_data);
      cpu_in_rd = 1'b1;
      step;
      chk($sformatf("wrap_cnt%0d", i), 32'(in_count), 1);
    end
    ext_in_valid = 1'b0;
    chk("wrap_head9", 32'(in_port), 32'(in_q.pop_front()));
    step;
    cpu_in_rd = 1'b0;
    chk("wrap_end_cnt", 32'(in_count), 0);
    int_ack = 1'b1;
    step;
    int_ack = 1'b0;
    rti_done = 1'b1;
    step;
    rti_done = 1'b0;
    step;
    chk("wrap_end_irq", 32'(irq), 0);
    // output FIFO full with a same-cycle write and drain: both take effect, no overflow
    for (int i = 0; i < 4; i++) begin
      cpu_out_wr = 1'b1;
      cpu_out_data = 16'h0010 + 16'(i);
      out_q.push_back(cpu_out_data);
      step;
    end
    cpu_out_data = 16'h0014;
    ext_out_ready = 1'b1;
    chk("full_rw_head", 32'(ext_out_data), 32'(out_q.pop_front()));
    out_q.push_back(16'h0014);
    step;
    cpu_out_wr = 1'b0;
    ext_out_ready = 1'b0;
    chk("full_rw_ovf", 32'(out_overflow), 0);
    drain("full_rw_drain");
    // output overflow: the fifth write is dropped and flagged
    for (int i = 1; i <= 5; i++) begin
      cpu_out_wr = 1'b1;
      cpu_out_data = 16'(i);
      if (i < 5) out_q.push_back(cpu_out_data);
      step;
    end
    cpu_out_wr = 1'b0;
    chk("ovf_flag", 32'(out_overflow), 1);
    chk("ovf_valid", 32'(ext_out_valid), 1);
    drain("ovf_drain");
    chk("ovf_sticky", 32'(out_overflow), 1);
    // asynchronous reset mid-operation with words queued on both sides
    ext_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ext_in_data = 16'h0700 + 16'(i);
      cpu_out_wr = 1'b1;
      cpu_out_data = 16'h0900 + 16'(i);
      step;
    end
    {ext_in_valid, cpu_out_wr} = '0;
    step;
    chk("pre_rst_cnt", 32'(in_count), 3);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    step;
    chk_reset("rst_after");
`ifdef IO_IRQ_THRESHOLD_EN
    ext_in_valid = 1'b1;
    ext_in_data = 16'h0A01;
    step;
    ext_in_valid = 1'b0;
    chk("thr_one_a", 32'(irq), 0);
    step;
    chk("thr_one_b", 32'(irq), 0);
    ext_in_valid = 1'b1;
    ext_in_data = 16'h0A02;
    step;
    ext_in_valid = 1'b0;
    chk("thr_two_edge", 32'(irq), 0);
    step;
    chk("thr_two_next", 32'(irq), 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
